quicksort_host: RTL
===================

// Module: quicksort_host
// PURPOSE
//  Host-side sequencer for the toggle-command quicksort engine. Accepts a valid/ready input stream and
//  issues clear and push toggles per item. On the last item it issues sort and waits for completion,
//  then pops every item into a valid/ready output stream. Sits between a stream source/sink and one
//  engine instance; both share clk/rstn.
// PARAMETERS
//  A_D_MSB  7  data MSB; must match the engine.
//  A_P_MSB  3  engine size parameter. Address width AW = 2**A_P_MSB. Capacity CAP = 2**AW - 1 (255 by default).
// PORTS
//  clk        in   1        single clock, rising edge
//  rstn       in   1        reset, asynchronous, active-low; the same net also resets the engine
//  s_valid    in   1        input item valid
//  s_ready    out  1        input item accepted when s_valid & s_ready
//  s_data     in   A_D_MSB+1  input item
//  s_last     in   1        marks the final item of a batch
//  m_valid    out  1        output item valid
//  m_ready    in   1        output item taken when m_valid & m_ready
//  m_data     out  A_D_MSB+1  output item
//  m_last     out  1        marks the final output item of a batch
//  e_enable   out  1        engine enable; constant 1 after reset
//  e_clear    out  1        engine clear command (toggle)
//  e_push     out  1        engine push command (toggle)
//  e_pop      out  1        engine pop command (toggle)
//  e_sort     out  1        engine sort command (toggle)
//  e_rx_data  out  A_D_MSB+1  data to the engine for push
//  e_tx_data  in   A_D_MSB+1  data from the engine after pop
//  e_idle     in   1        engine main FSM idle
//  busy       out  1        high whenever the FSM is not in S_IDLE
//  ovf        out  1        sticky; cleared at the start of the next batch
// BEHAVIOUR
//  Reset values: all toggles 0, e_enable 0 then 1, s_ready 0, m_valid 0, m_last 0, m_data 0,
//   e_rx_data 0, busy 0, ovf 0, count 0.
//  Command rule: a command is one inversion of one toggle output, registered.
//   - The cycle after a toggle is GAP; e_idle is ignored in GAP.
//   - Next the sequencer is in WAIT until e_idle==1. The command completes on that cycle.
//   - Never two toggles in flight. Minimum command cost is 3 cycles.
//  Main FSM states:
//   - S_IDLE: s_ready=0. If s_valid, go to S_CLR.
//   - S_CLR: issue clear; on completion set count=0, ovf=0, go to S_LOAD.
//   - S_LOAD: s_ready=1 for exactly one cycle, then 0 until the push completes.
//     - On accept with count<CAP: drive e_rx_data=s_data in the same cycle the push toggles, count++.
//     - On accept with count==CAP: drop the item and set ovf.
//     - If the accepted item had s_last: go to S_SORT if count>=2 (post-update), else S_DRAIN.
//       Sort is skipped for 0/1 items; the engine must not sort an empty array.
//   - S_SORT: issue sort; WAIT covers the whole engine run. On completion go to S_DRAIN.
//   - S_DRAIN: while count>0: issue pop; on completion capture e_tx_data into m_data, m_valid=1,
//     m_last=(count==1), count--. Hold m_data stable until m_ready. The next pop is issued only
//     after the handshake.
//     - When count reaches 0 after the handshake, go to S_IDLE.
//     - count==0 on entry: no output, go to S_IDLE. A batch that is only dropped items produces no output.
//  Output order: descending (largest first), because the engine sorts ascending and pops from the top.
//   Duplicates are preserved.
//  Width rules: count is AW bits, saturating at CAP, with no wrap. Data passes through unmodified.
//  Simultaneous events:
//   - s_valid with m_ready pending is impossible; load and drain never overlap.
//   - s_valid during S_DRAIN/S_SORT is ignored, with s_ready=0.
//  Reset mid-operation: everything returns to reset values at once. Partial output is discarded and
//   the engine is reset by the shared rstn.
// STRUCTURE
//  Package quicksort_pkg:
//   - GRAY macro/function
//   - main state localparams: S_IDLE, S_CLR, S_LOAD, S_SORT, S_DRAIN
//   - command codes: CMD_CLR, CMD_PUSH, CMD_POP, CMD_SORT
//   - CAP computed from A_P_MSB
//  Sub-module qs_cmd_issuer:
//   - holds the four toggle flops and the ISSUE/GAP/WAIT FSM
//   - inputs: cmd_valid, cmd_code, e_idle
//   - outputs: cmd_ready, cmd_done (1-cycle pulse)
//  Top = main FSM + count + stream registers.
// TESTING (bench instantiates quicksort_host + quicksort engine, A_P_MSB=3)
//  1 Stream 5,3,9,1,7 (last on 7), m_ready=1 -> out 9,7,5,3,1; m_last only with 1; ovf=0.
//  2 Single item 42 with s_last -> no sort toggle seen; out 42 with m_last=1.
//  3 Stream 4,4,2,4 -> out 4,4,4,2; then a second batch 8,0 -> out 8,0 (clear between batches).
//  4 Stream 257 items, values i mod 256 -> ovf=1; exactly 255 outputs, non-increasing.
//  5 m_ready toggled randomly 50% during drain -> m_data stable while stalled; no lost or extra items;
//    at most one toggle per GAP+WAIT window.
//  6 Assert rstn low mid-sort, release, run scenario 1 again -> identical result; all outputs at reset values while low.

Source files
------------

// File: rtl/quicksort_host_pkg.sv
// rtl/quicksort_host_pkg.sv - shared types, command codes and sizing helpers for the quicksort host
package quicksort_host_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_SORT,
        S_DRAIN
    } state_t;

    // Bit position of each command inside the toggle vector {sort, pop, push, clear}
    typedef enum logic [1:0] {
        CMD_CLR  = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2,
        CMD_SORT = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        C_ISSUE,
        C_GAP,
        C_WAIT
    } cmd_state_t;

    // Engine capacity: one address code is reserved, so 2**AW - 1 usable slots
    function automatic int cap_of(input int p_msb);
        return (2 ** (2 ** p_msb)) - 1;
    endfunction

    function automatic logic [31:0] gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/quicksort_host_if.sv
// rtl/quicksort_host_if.sv - stream and engine signal bundle between host sequencer and its environment
interface quicksort_host_if #(
    parameter int A_D_MSB = 7
);
    logic             s_valid;
    logic             s_ready;
    logic [A_D_MSB:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [A_D_MSB:0] m_data;
    logic             m_last;
    logic             e_enable;
    logic             e_clear;
    logic             e_push;
    logic             e_pop;
    logic             e_sort;
    logic [A_D_MSB:0] e_rx_data;
    logic [A_D_MSB:0] e_tx_data;
    logic             e_idle;
    logic             busy;
    logic             ovf;

    modport master (
        input  s_valid, s_data, s_last, m_ready, e_tx_data, e_idle,
        output s_ready, m_valid, m_data, m_last, e_enable, e_clear, e_push,
               e_pop, e_sort, e_rx_data, busy, ovf
    );

    modport slave (
        output s_valid, s_data, s_last, m_ready, e_tx_data, e_idle,
        input  s_ready, m_valid, m_data, m_last, e_enable, e_clear, e_push,
               e_pop, e_sort, e_rx_data, busy, ovf
    );
endinterface

// File: rtl/quicksort_host_cmd_issuer.sv
// rtl/quicksort_host_cmd_issuer.sv - toggle command issuer with ISSUE/GAP/WAIT handshake to the engine
module qs_cmd_issuer
    import quicksort_host_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic cmd_valid_i,
    input  cmd_t cmd_code_i,
    input  logic e_idle_i,
    output logic cmd_ready_o,
    output logic cmd_done_o,
    output logic e_clear_o,
    output logic e_push_o,
    output logic e_pop_o,
    output logic e_sort_o
);

    cmd_state_t state_q, state_d;
    logic [3:0] tog_q, tog_d;

    // State and toggle registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= C_ISSUE;
            tog_q   <= '0;
        end else begin
            state_q <= state_d;
            tog_q   <= tog_d;
        end
    end

    // One toggle per command; e_idle is not trusted until the engine has had a cycle to see the toggle
    always_comb begin
        state_d     = state_q;
        tog_d       = tog_q;
        cmd_ready_o = 1'b0;
        cmd_done_o  = 1'b0;
        case (state_q)
            C_ISSUE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    tog_d   = tog_q ^ (4'b0001 << cmd_code_i);
                    state_d = C_GAP;
                end
            end
            C_GAP:   state_d = C_WAIT;
            C_WAIT: begin
                if (e_idle_i) begin
                    cmd_done_o = 1'b1;
                    state_d    = C_ISSUE;
                end
            end
            default: state_d = C_ISSUE;
        endcase
    end

    assign e_clear_o = tog_q[CMD_CLR];
    assign e_push_o  = tog_q[CMD_PUSH];
    assign e_pop_o   = tog_q[CMD_POP];
    assign e_sort_o  = tog_q[CMD_SORT];

endmodule

// File: rtl/quicksort_host.sv
// rtl/quicksort_host.sv - host sequencer: load stream into engine, sort, drain in descending order
module quicksort_host
    import quicksort_host_pkg::*;
#(
    parameter int A_D_MSB = 7,
    parameter int A_P_MSB = 3
) (
    input  logic             clk,
    input  logic             rstn,
    quicksort_host_if.master bus
);

    localparam int             AW    = 2 ** A_P_MSB;
    localparam int             CAP_I = cap_of(A_P_MSB);
    localparam logic [AW-1:0]  CAP   = AW'(CAP_I);

    state_t           state_q, state_d;
    logic [AW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             last_q, last_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic [A_D_MSB:0] m_data_q, m_data_d;
    logic [A_D_MSB:0] rx_q, rx_d;
    logic             en_q;
    logic             s_ready;
    logic             cmd_valid, cmd_ready, cmd_done;
    cmd_t             cmd_code;

    qs_cmd_issuer u_issuer (
        .clk_i       (clk),
        .rst_n_i     (rstn),
        .cmd_valid_i (cmd_valid),
        .cmd_code_i  (cmd_code),
        .e_idle_i    (bus.e_idle),
        .cmd_ready_o (cmd_ready),
        .cmd_done_o  (cmd_done),
        .e_clear_o   (bus.e_clear),
        .e_push_o    (bus.e_push),
        .e_pop_o     (bus.e_pop),
        .e_sort_o    (bus.e_sort)
    );

    // Main state, item count and output stream registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            last_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            rx_q      <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            last_q    <= last_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            rx_q      <= rx_d;
            en_q      <= 1'b1;
        end
    end

    // Batch sequencing; commands are only offered while the issuer is free, so none overlap
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        last_d    = last_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        rx_d      = rx_q;
        cmd_valid = 1'b0;
        cmd_code  = CMD_CLR;
        s_ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.s_valid) state_d = S_CLR;
            end
            S_CLR: begin
                cmd_valid = cmd_ready;
                cmd_code  = CMD_CLR;
                if (cmd_done) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Ready drops while the push of the previous item is in flight
                s_ready = cmd_ready;
                if (s_ready && bus.s_valid) begin
                    if (count_q != CAP) begin
                        cmd_valid = 1'b1;
                        cmd_code  = CMD_PUSH;
                        rx_d      = bus.s_data;
                        count_d   = count_q + AW'(1);
                        last_d    = bus.s_last;
                    end else begin
                        // Engine full: item is dropped, so a final item can move on at once
                        ovf_d = 1'b1;
                        if (bus.s_last) state_d = S_SORT;
                    end
                end
                if (cmd_done && last_q) begin
                    last_d  = 1'b0;
                    state_d = (count_q >= AW'(2)) ? S_SORT : S_DRAIN;
                end
            end
            S_SORT: begin
                cmd_valid = cmd_ready;
                cmd_code  = CMD_SORT;
                if (cmd_done) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (m_valid_q) begin
                    if (bus.m_ready) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        if (count_q == '0) state_d = S_IDLE;
                    end
                end else if (count_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cmd_valid = cmd_ready;
                    cmd_code  = CMD_POP;
                    if (cmd_done) begin
                        m_data_d  = bus.e_tx_data;
                        m_valid_d = 1'b1;
                        m_last_d  = (count_q == AW'(1));
                        count_d   = count_q - AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_last    = m_last_q;
    assign bus.e_rx_data = rx_q;
    assign bus.e_enable  = en_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ovf       = ovf_q;

endmodule
